// File: rtl/serial_add_arb.sv
// rtl/serial_add_arb.sv - four-client round-robin front end for one bit-serial adder
//
// Ports:
//   clk      - clock, all state changes on posedge
//   rst      - synchronous active-high reset
//   req      - per-client request level, client i on bit i
//   a_in     - packed operand A, client i at [i*W +: W]
//   b_in     - packed operand B, client i at [i*W +: W]
//   cin_in   - per-client carry-in
//   gnt      - one-hot grant of the client being served, zero when idle
//   busy     - high whenever a job is in progress (RUN or DONE)
//   done     - one-cycle pulse on the bit of the client whose result is ready
//   sum_out  - registered sum, valid from the done cycle until the next one
//   cout_out - registered carry-out, same timing as sum_out
module serial_add_arb #(
  parameter int W     = 8,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         req,
  input  logic [4*W-1:0]     a_in,
  input  logic [4*W-1:0]     b_in,
  input  logic [3:0]         cin_in,
  output logic [3:0]         gnt,
  output logic               busy,
  output logic [3:0]         done,
  output logic [W-1:0]       sum_out,
  output logic               cout_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [1:0]         rr_ptr;
  logic [1:0]         win_idx;
  logic [1:0]         cur_idx;
  logic [CNT_W-1:0]   cnt;
  logic [W-1:0]       a_sr;
  logic [W-1:0]       b_sr;
  logic [W-1:0]       sum_sr;
  logic               carry;
  logic [1:0]         bit_sum;
  logic               last_bit;

  // Round-robin pick: scan rr_ptr, rr_ptr+1, ... and take the first requester.
  always_comb begin
    logic       found;
    logic [1:0] idx;
    found   = 1'b0;
    win_idx = rr_ptr;
    idx     = rr_ptr;
    for (int k = 0; k < 4; k++) begin
      idx = rr_ptr + 2'(k);
      if (!found && req[idx]) begin
        found   = 1'b1;
        win_idx = idx;
      end
    end
  end

  assign bit_sum  = {1'b0, a_sr[0]} + {1'b0, b_sr[0]} + {1'b0, carry};
  assign last_bit = (cnt == CNT_W'(W - 1));
  assign busy     = (state != IDLE);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req != 4'b0000) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= 2'd0;
      cur_idx  <= 2'd0;
      cnt      <= '0;
      a_sr     <= '0;
      b_sr     <= '0;
      sum_sr   <= '0;
      carry    <= 1'b0;
      gnt      <= 4'b0000;
      done     <= 4'b0000;
      sum_out  <= '0;
      cout_out <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (req != 4'b0000) begin
            cur_idx <= win_idx;
            gnt     <= 4'b0001 << win_idx;
            a_sr    <= a_in[win_idx*W +: W];
            b_sr    <= b_in[win_idx*W +: W];
            carry   <= cin_in[win_idx];
            cnt     <= '0;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          sum_sr <= {bit_sum[0], sum_sr[W-1:1]};
          carry  <= bit_sum[1];
          cnt    <= cnt + 1'b1;
          // Final bit: publish the result so it is visible in the DONE cycle.
          if (last_bit) begin
            sum_out  <= {bit_sum[0], sum_sr[W-1:1]};
            cout_out <= bit_sum[1];
            done     <= 4'b0001 << cur_idx;
          end
        end
        DONE: begin
          gnt    <= 4'b0000;
          done   <= 4'b0000;
          rr_ptr <= cur_idx + 2'd1;
        end
        default: begin
          gnt  <= 4'b0000;
          done <= 4'b0000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_arb.sv
// tb/tb_serial_add_arb.sv - directed self-checking bench for serial_add_arb
module tb_serial_add_arb;

  localparam int W = 8;

  logic           clk;
  logic           rst;
  logic [3:0]     req;
  logic [4*W-1:0] a_in;
  logic [4*W-1:0] b_in;
  logic [3:0]     cin_in;
  logic [3:0]     gnt;
  logic           busy;
  logic [3:0]     done;
  logic [W-1:0]   sum_out;
  logic           cout_out;

  int checks;
  int failures;

  serial_add_arb #(.W(W), .CNT_W(6)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .a_in     (a_in),
    .b_in     (b_in),
    .cin_in   (cin_in),
    .gnt      (gnt),
    .busy     (busy),
    .done     (done),
    .sum_out  (sum_out),
    .cout_out (cout_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst    = 1'b1;
    req    = 4'b0000;
    a_in   = '0;
    b_in   = '0;
    cin_in = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Waits (sampling on negedges) until done is non-zero; cyc = -1 on timeout.
  task automatic wait_done(input int budget, output int cyc, output logic [3:0] dv,
                           output logic [3:0] gnt_seen);
    cyc      = -1;
    dv       = 4'b0000;
    gnt_seen = 4'b0000;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      gnt_seen = gnt_seen | gnt;
      if (done != 4'b0000) begin
        cyc = i;
        dv  = done;
        return;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 4'b0000; a_in = '0; b_in = '0; cin_in = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
    checks++; if (done !== 4'b0000) begin failures++; $display("FAIL reset_done got=%b exp=0000", done); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (sum_out !== 8'h00) begin failures++; $display("FAIL reset_sum got=%h exp=00", sum_out); end
    checks++; if (cout_out !== 1'b0) begin failures++; $display("FAIL reset_cout got=%b exp=0", cout_out); end
  endtask

  task automatic test_single_client();
    int bad_gnt;
    int bad_done;
    do_reset();
    a_in[2*W +: W] = 8'hFF;
    b_in[2*W +: W] = 8'h01;
    cin_in[2]      = 1'b0;
    req            = 4'b0100;
    bad_gnt  = 0;
    bad_done = 0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (gnt !== 4'b0100 || busy !== 1'b1) bad_gnt++;
      if (k < 9 && done !== 4'b0000) bad_done++;
      if (k == 9) begin
        req = 4'b0000;
        checks++; if (done !== 4'b0100) begin failures++; $display("FAIL single_done got=%b exp=0100", done); end
        checks++; if (sum_out !== 8'h00) begin failures++; $display("FAIL single_sum got=%h exp=00", sum_out); end
        checks++; if (cout_out !== 1'b1) begin failures++; $display("FAIL single_cout got=%b exp=1", cout_out); end
      end
    end
    checks++; if (bad_gnt != 0) begin failures++; $display("FAIL single_gnt_window bad_cycles=%0d exp=0", bad_gnt); end
    checks++; if (bad_done != 0) begin failures++; $display("FAIL single_early_done bad_cycles=%0d exp=0", bad_done); end
    @(negedge clk);
    checks++; if (gnt !== 4'b0000 || busy !== 1'b0 || done !== 4'b0000) begin
      failures++; $display("FAIL single_after gnt=%b busy=%b done=%b exp=0000/0/0000", gnt, busy, done);
    end
  endtask

  task automatic test_back_to_back();
    int         cyc;
    logic [3:0] dv;
    logic [3:0] gs;
    logic [3:0] exp_d;
    do_reset();
    req = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      wait_done(30, cyc, dv, gs);
      exp_d = 4'b0001 << (j % 4);
      checks++; if (dv !== exp_d) begin failures++; $display("FAIL b2b_order job=%0d got=%b exp=%b", j, dv, exp_d); end
      checks++; if (cyc != ((j == 0) ? 9 : 10)) begin
        failures++; $display("FAIL b2b_spacing job=%0d got=%0d exp=%0d", j, cyc, (j == 0) ? 9 : 10);
      end
      checks++; if (gnt !== dv) begin failures++; $display("FAIL b2b_gnt_eq_done job=%0d gnt=%b done=%b", j, gnt, dv); end
    end
    req = 4'b0000;
  endtask

  task automatic test_two_clients();
    int         cyc;
    logic [3:0] dv;
    logic [3:0] gs;
    logic [3:0] all_gs;
    logic [3:0] exp_d;
    do_reset();
    req    = 4'b1001;
    all_gs = 4'b0000;
    for (int j = 0; j < 4; j++) begin
      wait_done(30, cyc, dv, gs);
      all_gs = all_gs | gs;
      exp_d  = (j % 2 == 0) ? 4'b0001 : 4'b1000;
      checks++; if (dv !== exp_d) begin failures++; $display("FAIL two_order job=%0d got=%b exp=%b", j, dv, exp_d); end
    end
    checks++; if (all_gs !== 4'b1001) begin failures++; $display("FAIL two_starve gnt_seen=%b exp=1001", all_gs); end
    req = 4'b0000;
  endtask

  task automatic test_operand_change();
    int         cyc;
    logic [3:0] dv;
    logic [3:0] gs;
    do_reset();
    a_in[1*W +: W] = 8'h5A;
    b_in[1*W +: W] = 8'h3C;
    cin_in         = 4'b0010;
    req            = 4'b0010;
    @(negedge clk);
    a_in   = {4{8'hC3}};
    b_in   = {4{8'h77}};
    cin_in = 4'b0000;
    req    = 4'b0000;
    wait_done(20, cyc, dv, gs);
    checks++; if (dv !== 4'b0010 || cyc != 8) begin failures++; $display("FAIL opchg_done got=%b@%0d exp=0010@8", dv, cyc); end
    checks++; if (sum_out !== 8'h97) begin failures++; $display("FAIL opchg_sum got=%h exp=97", sum_out); end
    checks++; if (cout_out !== 1'b0) begin failures++; $display("FAIL opchg_cout got=%b exp=0", cout_out); end
    repeat (3) @(negedge clk);
    checks++; if (sum_out !== 8'h97 || cout_out !== 1'b0) begin
      failures++; $display("FAIL opchg_hold got=%h/%b exp=97/0", sum_out, cout_out);
    end
  endtask

  task automatic test_max_operands();
    int         cyc;
    logic [3:0] dv;
    logic [3:0] gs;
    do_reset();
    a_in[3*W +: W] = 8'hFF;
    b_in[3*W +: W] = 8'hFF;
    cin_in         = 4'b1000;
    req            = 4'b1000;
    wait_done(20, cyc, dv, gs);
    req = 4'b0000;
    checks++; if (dv !== 4'b1000) begin failures++; $display("FAIL max_done got=%b exp=1000", dv); end
    checks++; if (sum_out !== 8'hFF) begin failures++; $display("FAIL max_sum got=%h exp=ff", sum_out); end
    checks++; if (cout_out !== 1'b1) begin failures++; $display("FAIL max_cout got=%b exp=1", cout_out); end
  endtask

  task automatic test_reset_abort();
    int         cyc;
    logic [3:0] dv;
    logic [3:0] gs;
    int         seen_done;
    do_reset();
    a_in[0 +: W] = 8'h03;
    b_in[0 +: W] = 8'h04;
    req          = 4'b0001;
    wait_done(20, cyc, dv, gs);
    req = 4'b0000;
    checks++; if (sum_out !== 8'h07) begin failures++; $display("FAIL abort_pre_sum got=%h exp=07", sum_out); end
    @(negedge clk);
    req       = 4'b1111;
    seen_done = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (done !== 4'b0000) seen_done++;
    end
    checks++; if (gnt !== 4'b0010) begin failures++; $display("FAIL abort_pre_gnt got=%b exp=0010", gnt); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    if (done !== 4'b0000) seen_done++;
    checks++; if (gnt !== 4'b0000 || busy !== 1'b0) begin
      failures++; $display("FAIL abort_idle gnt=%b busy=%b exp=0000/0", gnt, busy);
    end
    checks++; if (sum_out !== 8'h00 || cout_out !== 1'b0) begin
      failures++; $display("FAIL abort_result got=%h/%b exp=00/0", sum_out, cout_out);
    end
    checks++; if (seen_done != 0) begin failures++; $display("FAIL abort_no_done pulses=%0d exp=0", seen_done); end
    @(negedge clk);
    checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL abort_next_gnt got=%b exp=0001", gnt); end
    req = 4'b0000;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    req      = 4'b0000;
    a_in     = '0;
    b_in     = '0;
    cin_in   = 4'b0000;
    test_reset();
    test_single_client();
    test_back_to_back();
    test_two_clients();
    test_operand_change();
    test_max_operands();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
